// File: rtl/nand_pipe_ctrl.sv
// Pipeline control for the STAGES-deep NAND CPU: destination tracking, RAW stall/forward, branch squash, halt drain.
// Optional feature macro: NAND_FWD_EN (adds fwd_sel_a/fwd_sel_b and forwarding instead of stalling).
module nand_pipe_ctrl #(
    parameter int STAGES = 4,
    parameter int REG_AW = 2
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      d_valid,
    input  logic [REG_AW-1:0]         d_src_a,
    input  logic [REG_AW-1:0]         d_src_b,
    input  logic                      d_src_a_used,
    input  logic                      d_src_b_used,
    input  logic [REG_AW-1:0]         d_dst,
    input  logic                      d_wr_en,
    input  logic                      d_is_load,
    input  logic                      d_is_halt,
    input  logic                      br_taken,
    output logic                      stall_f,
    output logic                      bubble_d,
    output logic                      flush,
    output logic                      halt,
    output logic [STAGES-3:0]         stage_valid
`ifdef NAND_FWD_EN
    ,
    output logic [$clog2(STAGES)-1:0] fwd_sel_a,
    output logic [$clog2(STAGES)-1:0] fwd_sel_b
`endif
);

    localparam int NT = STAGES - 2;   // tracker entries, stages 2..STAGES-1
    localparam int NW = STAGES - 3;   // hazard window entries, stages 2..STAGES-2
    localparam int CW = $clog2(STAGES);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [NT-1:0]     r_vld;
    logic [REG_AW-1:0] r_dst [NW];
    logic [NW-1:0]     r_wr;
    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;

    logic w_hit_a;
    logic w_hit_b;
    logic w_haz;

`ifdef NAND_FWD_EN
    logic          r_ld0;
    logic          w_lu_a;
    logic          w_lu_b;
    logic [CW-1:0] w_sel_a;
    logic [CW-1:0] w_sel_b;
`else
    logic          w_unused;
    assign w_unused = d_is_load;
`endif

    // Scan the window oldest to youngest so the youngest matching producer wins.
    always_comb begin
        w_hit_a = 1'b0;
        w_hit_b = 1'b0;
`ifdef NAND_FWD_EN
        w_lu_a  = 1'b0;
        w_lu_b  = 1'b0;
        w_sel_a = '0;
        w_sel_b = '0;
`endif
        for (int k = NW - 1; k >= 0; k--) begin
            if (r_vld[k] && r_wr[k] && d_src_a_used && (r_dst[k] == d_src_a)) begin
                w_hit_a = 1'b1;
`ifdef NAND_FWD_EN
                w_sel_a = CW'(k + 2);
                w_lu_a  = (k == 0) && r_ld0;
`endif
            end
            if (r_vld[k] && r_wr[k] && d_src_b_used && (r_dst[k] == d_src_b)) begin
                w_hit_b = 1'b1;
`ifdef NAND_FWD_EN
                w_sel_b = CW'(k + 2);
                w_lu_b  = (k == 0) && r_ld0;
`endif
            end
        end
    end

`ifdef NAND_FWD_EN
    assign w_haz     = d_valid && (w_lu_a || w_lu_b);
    assign fwd_sel_a = (w_hit_a && !w_haz) ? w_sel_a : '0;
    assign fwd_sel_b = (w_hit_b && !w_haz) ? w_sel_b : '0;
`else
    assign w_haz     = d_valid && (w_hit_a || w_hit_b);
`endif

    // A taken branch squashes decode and overrides any hazard stall.
    always_comb begin
        stall_f  = 1'b0;
        bubble_d = 1'b0;
        flush    = 1'b0;
        if (n_rst) begin
            if (r_state == S_RUN) begin
                if (br_taken) begin
                    flush    = 1'b1;
                    bubble_d = 1'b1;
                end else begin
                    stall_f  = w_haz;
                    bubble_d = w_haz;
                end
            end else begin
                stall_f  = 1'b1;
                bubble_d = 1'b1;
            end
        end
    end

    assign halt        = (r_state == S_HALTED);
    assign stage_valid = r_vld;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_vld   <= '0;
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_vld <= {r_vld[NT-2:0], d_valid & ~bubble_d};
            case (r_state)
                S_RUN: begin
                    if (d_valid && d_is_halt && !stall_f && !flush) begin
                        r_state <= S_DRAIN;
                        r_cnt   <= CW'(STAGES - 2);
                    end
                end
                S_DRAIN: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_HALTED;
                    end
                end
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_RUN;
            endcase
        end
    end

    // Register payload is qualified by r_vld, so it carries no reset.
    always_ff @(posedge clk) begin
        r_dst[0] <= d_dst;
        r_wr[0]  <= d_wr_en;
        for (int k = 1; k < NW; k++) begin
            r_dst[k] <= r_dst[k-1];
            r_wr[k]  <= r_wr[k-1];
        end
`ifdef NAND_FWD_EN
        r_ld0 <= d_is_load;
`endif
    end

endmodule
